// File: rtl/rv_pkg.sv
// Shared RV definitions: 5-bit opcode classes, datapath defaults and forward-select encoding.
package rv_pkg;

  localparam int unsigned XLEN_DEFAULT   = 32;
  localparam int unsigned REG_AW_DEFAULT = 5;
  localparam int unsigned OPC_W          = 5;
  localparam int unsigned CNT_W          = 32;

  // Instruction classes, encoded as opcode[6:2]
  localparam logic [OPC_W-1:0] R_R    = 5'h0C;
  localparam logic [OPC_W-1:0] R_I    = 5'h04;
  localparam logic [OPC_W-1:0] LUI    = 5'h0D;
  localparam logic [OPC_W-1:0] AUIPC  = 5'h05;
  localparam logic [OPC_W-1:0] LOAD   = 5'h00;
  localparam logic [OPC_W-1:0] STORE  = 5'h08;
  localparam logic [OPC_W-1:0] JAL    = 5'h1B;
  localparam logic [OPC_W-1:0] JALR   = 5'h19;
  localparam logic [OPC_W-1:0] BRANCH = 5'h18;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID->EX boundary bundle: decode handshake, flush/stall, MEM/WB bypass sources and EX outputs.
interface id_ex_stage_if #(
  parameter int unsigned XLEN   = rv_pkg::XLEN_DEFAULT,
  parameter int unsigned REG_AW = rv_pkg::REG_AW_DEFAULT
);
  logic              id_valid;
  logic              id_ready;
  logic [4:0]        id_opcode;
  logic [2:0]        id_func3;
  logic [1:0]        id_func7;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [XLEN-1:0]   id_pc;
  logic              id_src1_pc;
  logic              id_src2_imm;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;
  logic              ex_stall;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_reg_write;
  logic [XLEN-1:0]   mem_fwd_data;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_reg_write;
  logic [XLEN-1:0]   wb_data;
  logic              ex_valid;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic [4:0]        ex_opcode;
  logic [2:0]        ex_func3;
  logic [1:0]        ex_func7;
  logic [REG_AW-1:0] ex_rd;
  logic [XLEN-1:0]   ex_alu_src1;
  logic [XLEN-1:0]   ex_alu_src2;
  logic [XLEN-1:0]   ex_store_data;
  logic [XLEN-1:0]   ex_pc;
  logic [31:0]       bubble_cnt;

  modport master (
    output id_valid, id_opcode, id_func3, id_func7, id_rs1, id_rs2, id_rd,
           id_rs1_data, id_rs2_data, id_imm, id_pc, id_src1_pc, id_src2_imm,
           id_reg_write, id_mem_read, flush, ex_stall,
           mem_rd, mem_reg_write, mem_fwd_data, wb_rd, wb_reg_write, wb_data,
    input  id_ready, ex_valid, ex_reg_write, ex_mem_read, ex_opcode, ex_func3,
           ex_func7, ex_rd, ex_alu_src1, ex_alu_src2, ex_store_data, ex_pc, bubble_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_func3, id_func7, id_rs1, id_rs2, id_rd,
           id_rs1_data, id_rs2_data, id_imm, id_pc, id_src1_pc, id_src2_imm,
           id_reg_write, id_mem_read, flush, ex_stall,
           mem_rd, mem_reg_write, mem_fwd_data, wb_rd, wb_reg_write, wb_data,
    output id_ready, ex_valid, ex_reg_write, ex_mem_read, ex_opcode, ex_func3,
           ex_func7, ex_rd, ex_alu_src1, ex_alu_src2, ex_store_data, ex_pc, bubble_cnt
  );
endinterface

// File: rtl/fwd_unit.sv
// Operand bypass for one source register: MEM beats WB beats register-file data; x0 never bypassed.
module fwd_unit
  import rv_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [XLEN-1:0]   rf_data_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_we_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_we_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic [XLEN-1:0]   data_o
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_RF;
    if (rs_i != '0) begin
      if (mem_we_i && (mem_rd_i == rs_i)) begin
        sel = FWD_MEM;
      end else if (wb_we_i && (wb_rd_i == rs_i)) begin
        sel = FWD_WB;
      end
    end
  end

  always_comb begin
    data_o = rf_data_i;
    unique case (sel)
      FWD_MEM: data_o = mem_data_i;
      FWD_WB:  data_o = wb_data_i;
      default: data_o = rf_data_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard bubbling and operand bypass.
// Define EX_FORWARD_EN to bypass from MEM/WB (stall on load-use only); otherwise stall on any pending writer.
module id_ex_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  logic              ex_valid_q, ex_valid_d;
  logic              ex_reg_write_q, ex_reg_write_d;
  logic              ex_mem_read_q, ex_mem_read_d;
  logic [OPC_W-1:0]  ex_opcode_q;
  logic [2:0]        ex_func3_q;
  logic [1:0]        ex_func7_q;
  logic [REG_AW-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
  logic [XLEN-1:0]   ex_rs1_data_q, ex_rs2_data_q, ex_imm_q, ex_pc_q;
  logic              ex_src1_pc_q, ex_src2_imm_q;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic              hazard, load, bubble;
  logic              mem_fwd_we, wb_fwd_we;
  logic [XLEN-1:0]   rs1_fwd, rs2_fwd;

  function automatic logic src_hit(input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] rs1,
                                   input logic [REG_AW-1:0] rs2);
    return (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

`ifdef EX_FORWARD_EN
  assign hazard     = ex_valid_q && ex_mem_read_q && src_hit(ex_rd_q, bus.id_rs1, bus.id_rs2);
  assign mem_fwd_we = bus.mem_reg_write;
  assign wb_fwd_we  = bus.wb_reg_write;
`else
  assign hazard     = (ex_valid_q && ex_reg_write_q && src_hit(ex_rd_q, bus.id_rs1, bus.id_rs2))
                   || (bus.mem_reg_write && src_hit(bus.mem_rd, bus.id_rs1, bus.id_rs2))
                   || (bus.wb_reg_write && src_hit(bus.wb_rd, bus.id_rs1, bus.id_rs2));
  assign mem_fwd_we = 1'b0;
  assign wb_fwd_we  = 1'b0;
`endif

  // flush always accepts (the ID slot is being discarded upstream anyway)
  assign bus.id_ready = rst_n && (bus.flush || (!bus.ex_stall && !hazard));
  assign load         = bus.id_valid && bus.id_ready && !bus.ex_stall && !bus.flush;
  assign bubble       = hazard && bus.id_valid && !bus.ex_stall && !bus.flush;

  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_mem_read_d  = ex_mem_read_q;
    bubble_cnt_d   = bubble_cnt_q;
    if (bus.flush || !bus.ex_stall) begin
      ex_valid_d     = load;
      ex_reg_write_d = load && bus.id_reg_write;
      ex_mem_read_d  = load && bus.id_mem_read;
    end
    if (bubble && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_opcode_q    <= '0;
      ex_func3_q     <= '0;
      ex_func7_q     <= '0;
      ex_rd_q        <= '0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_rs1_data_q  <= '0;
      ex_rs2_data_q  <= '0;
      ex_imm_q       <= '0;
      ex_pc_q        <= '0;
      ex_src1_pc_q   <= 1'b0;
      ex_src2_imm_q  <= 1'b0;
      bubble_cnt_q   <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      bubble_cnt_q   <= bubble_cnt_d;
      if (load) begin
        ex_opcode_q   <= bus.id_opcode;
        ex_func3_q    <= bus.id_func3;
        ex_func7_q    <= bus.id_func7;
        ex_rd_q       <= bus.id_rd;
        ex_rs1_q      <= bus.id_rs1;
        ex_rs2_q      <= bus.id_rs2;
        ex_rs1_data_q <= bus.id_rs1_data;
        ex_rs2_data_q <= bus.id_rs2_data;
        ex_imm_q      <= bus.id_imm;
        ex_pc_q       <= bus.id_pc;
        ex_src1_pc_q  <= bus.id_src1_pc;
        ex_src2_imm_q <= bus.id_src2_imm;
      end
    end
  end

  fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs_i       (ex_rs1_q),
    .rf_data_i  (ex_rs1_data_q),
    .mem_rd_i   (bus.mem_rd),
    .mem_we_i   (mem_fwd_we),
    .mem_data_i (bus.mem_fwd_data),
    .wb_rd_i    (bus.wb_rd),
    .wb_we_i    (wb_fwd_we),
    .wb_data_i  (bus.wb_data),
    .data_o     (rs1_fwd)
  );

  fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs_i       (ex_rs2_q),
    .rf_data_i  (ex_rs2_data_q),
    .mem_rd_i   (bus.mem_rd),
    .mem_we_i   (mem_fwd_we),
    .mem_data_i (bus.mem_fwd_data),
    .wb_rd_i    (bus.wb_rd),
    .wb_we_i    (wb_fwd_we),
    .wb_data_i  (bus.wb_data),
    .data_o     (rs2_fwd)
  );

  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_reg_write  = ex_reg_write_q;
  assign bus.ex_mem_read   = ex_mem_read_q;
  assign bus.ex_opcode     = ex_opcode_q;
  assign bus.ex_func3      = ex_func3_q;
  assign bus.ex_func7      = ex_func7_q;
  assign bus.ex_rd         = ex_rd_q;
  assign bus.ex_pc         = ex_pc_q;
  assign bus.ex_alu_src1   = ex_src1_pc_q ? ex_pc_q : rs1_fwd;
  assign bus.ex_alu_src2   = ex_src2_imm_q ? ex_imm_q : rs2_fwd;
  assign bus.ex_store_data = rs2_fwd;
  assign bus.bubble_cnt    = bubble_cnt_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width.
REQ-002 Parameter: REG_AW, 5, register index width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 id_valid / id_ready  in / out  1 / 1  decode-side handshake; transfer when both are high.
REQ-006 id_opcode / id_func3 / id_func7  in  5 / 3 / 2  decoded instruction class and function bits.
REQ-007 id_rs1, id_rs2, id_rd  in  REG_AW  source and destination register indices.
REQ-008 id_rs1_data, id_rs2_data, id_imm, id_pc  in  XLEN  register file reads, immediate, PC.
REQ-009 id_src1_pc, id_src2_imm, id_reg_write, id_mem_read  in  1  operand selects and control flags.
REQ-010 flush  in  1  kill the instruction in EX (branch/jump redirect).
REQ-011 ex_stall  in  1  downstream hold; EX contents frozen.
REQ-012 mem_rd / mem_reg_write / mem_fwd_data  in  REG_AW / 1 / XLEN  forwarding source from the MEM stage.
REQ-013 wb_rd / wb_reg_write / wb_data  in  REG_AW / 1 / XLEN  forwarding source from the WB stage.
REQ-014 ex_valid, ex_reg_write, ex_mem_read  out  1  EX-stage valid and control flags.
REQ-015 ex_opcode / ex_func3 / ex_func7 / ex_rd  out  5 / 3 / 2 / REG_AW  fields to the ALU and later stages.
REQ-016 ex_alu_src1, ex_alu_src2, ex_store_data, ex_pc  out  XLEN  ALU operands, store data, PC.
REQ-017 bubble_cnt  out  32  count of hazard bubbles inserted.

Function
REQ-018 A load occurs when id_valid && id_ready && !ex_stall && !flush; all EX registers capture their id_* inputs.
REQ-019 id_ready SHALL equal !ex_stall && !hazard, or 1 when flush is high.
REQ-020 hazard with forwarding: ex_valid && ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2); this gives exactly one bubble.
REQ-021 When !ex_stall and no load occurs (hazard, !id_valid, or flush): ex_valid, ex_reg_write and ex_mem_read clear to 0 next cycle; data fields are don't-care.
REQ-022 Priority: flush > ex_stall > hazard > load; flush during ex_stall still kills EX.
REQ-023 bubble_cnt increments by 1 per cycle with hazard && id_valid && !ex_stall && !flush, and saturates at 0xFFFF_FFFF.
REQ-024 Forwarding is combinational on the registered rs1/rs2. MEM match (mem_reg_write, mem_rd!=0, equal index) beats WB match; otherwise the registered register file data is used.
REQ-025 Register index 0 SHALL never be forwarded.
REQ-026 ex_alu_src1 = registered id_src1_pc ? ex_pc : forwarded rs1.
REQ-027 ex_alu_src2 = registered id_src2_imm ? imm : forwarded rs2.
REQ-028 ex_store_data = forwarded rs2, always.
REQ-029 Latency: one cycle from ID acceptance to EX outputs; no combinational id_* -> ex_* path except through id_ready.

Reset
REQ-030 On rst_n low, immediately: ex_valid, ex_reg_write, ex_mem_read = 0; all other ex_* registers = 0; bubble_cnt = 0.
REQ-031 id_ready SHALL be 0 while rst_n is low.
REQ-032 Reset mid-stall discards the held instruction.

Configuration
REQ-033 Macro EX_FORWARD_EN defined: forwarding per REQ-024 and hazard per REQ-020.
REQ-034 Macro EX_FORWARD_EN undefined: no forwarding, and operands are the registered register file data. hazard = any valid EX/MEM/WB writer with rd!=0 matching id_rs1 or id_rs2; ID stalls until it clears, and bubble_cnt counts every such cycle.

Structure
REQ-035 Shared package rv_pkg holds the 5-bit opcode constants (R_R, R_I, LUI, AUIPC, LOAD, STORE, JAL, JALR, BRANCH), the XLEN default and the forward-select enum (FWD_RF, FWD_MEM, FWD_WB).
REQ-036 One sub-module, fwd_unit, holds index compare and the operand mux, instantiated twice (rs1, rs2).

Verification
REQ-037 Load-use: LOAD x5 in EX, ID ADD x6,x5,x1 -> id_ready=0 one cycle, ex_valid=0 next cycle, bubble_cnt 0->1; ADD then takes WB data 0x1234.
REQ-038 Double match: MEM rd=3 data 0xAAAA, WB rd=3 data 0xBBBB, EX rs1=3 -> ex_alu_src1=0xAAAA.
REQ-039 x0: MEM rd=0 reg_write=1 data 0xFFFF, EX rs2=0, rf data 0 -> ex_alu_src2=0.
REQ-040 JAL: id_src1_pc=1, id_pc=0x100 -> ex_alu_src1=0x100; ex_stall held 3 cycles -> all ex_* outputs unchanged.
REQ-041 Flush while ex_stall=1 -> ex_valid=0 next cycle; rst_n pulse mid-stall -> all outputs 0 with no clock edge.
REQ-042 EX_FORWARD_EN undefined: ADD x2 in MEM, ID uses x2 -> stall until WB retires, 2 bubbles counted.
